// File: rtl/xillybus_ap_fifo_packer_if.sv
// Handshake bundle between the upstream source FIFO, the packer
// and the downstream HLS ap_fifo input.
interface xillybus_ap_fifo_packer_if #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
);
  logic [IN_W-1:0]       src_dout;
  logic                  src_empty;
  logic                  src_rd_en;
  logic                  src_open;
  logic [IN_W*RATIO-1:0] out_dout;
  logic                  out_empty_n;
  logic                  out_read;

  modport slave (
    input  src_dout,
    input  src_empty,
    input  src_open,
    input  out_read,
    output src_rd_en,
    output out_dout,
    output out_empty_n
  );

  modport master (
    output src_dout,
    output src_empty,
    output src_open,
    output out_read,
    input  src_rd_en,
    input  out_dout,
    input  out_empty_n
  );
endinterface

// File: rtl/xillybus_ap_fifo_packer.sv
// Packs RATIO words from a 1-cycle-latency source FIFO into one wide
// ap_fifo word, with optional zero-padded flush on stream close.
module xillybus_ap_fifo_packer #(
  parameter int IN_W         = 32,
  parameter int RATIO        = 4,
  parameter int PAD_ON_CLOSE = 1
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  xillybus_ap_fifo_packer_if.slave      bus,
  output logic [31:0]                   words_out,
  output logic                          pad_evt
);
  localparam int W  = IN_W * RATIO;
  localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

  logic [W-1:0]  acc;
  logic [W-1:0]  merged;
  logic [W-1:0]  ld_data;
  logic [LW-1:0] lane_cnt;
  logic          rd_pend;
  logic          acc_full;
  logic          pad_hold;
  logic          out_free;
  logic          last_lane;
  logic          complete;
  logic          flush;
  logic          ld;
  logic          ld_pad;

  assign out_free  = !bus.out_empty_n || bus.out_read;
  assign last_lane = (lane_cnt == LAST);
  assign complete  = rd_pend && last_lane;
  assign flush     = !bus.src_open && bus.src_empty && !rd_pend
                     && (lane_cnt != '0) && !acc_full;

  // Stall the read that would complete a word with nowhere to put it.
  assign bus.src_rd_en = !ap_rst && !bus.src_empty && !acc_full
                         && !(complete && !out_free);

  always_comb begin
    merged = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (lane_cnt == LW'(k)) merged[k*IN_W +: IN_W] = bus.src_dout;
    end
  end

  always_comb begin
    ld      = 1'b0;
    ld_data = merged;
    ld_pad  = 1'b0;
    if (acc_full) begin
      ld      = out_free;
      ld_data = acc;
      ld_pad  = pad_hold;
    end else if (complete) begin
      ld      = out_free;
    end else if (flush && PAD_ON_CLOSE != 0) begin
      ld      = out_free;
      ld_data = acc;
      ld_pad  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc             <= '0;
      lane_cnt        <= '0;
      rd_pend         <= 1'b0;
      acc_full        <= 1'b0;
      pad_hold        <= 1'b0;
      bus.out_dout    <= '0;
      bus.out_empty_n <= 1'b0;
      words_out       <= '0;
      pad_evt         <= 1'b0;
    end else begin
      rd_pend <= bus.src_rd_en;
      pad_evt <= ld && ld_pad;
      if (acc_full) begin
        if (out_free) begin
          acc_full <= 1'b0;
          acc      <= '0;
        end
      end else if (rd_pend) begin
        if (last_lane) begin
          lane_cnt <= '0;
          if (out_free) begin
            acc <= '0;
          end else begin
            acc      <= merged;
            acc_full <= 1'b1;
            pad_hold <= 1'b0;
          end
        end else begin
          acc      <= merged;
          lane_cnt <= lane_cnt + LW'(1);
        end
      end else if (flush) begin
        lane_cnt <= '0;
        if (PAD_ON_CLOSE != 0 && !out_free) begin
          acc_full <= 1'b1;
          pad_hold <= 1'b1;
        end else begin
          acc <= '0;
        end
      end
      if (ld) begin
        bus.out_dout    <= ld_data;
        bus.out_empty_n <= 1'b1;
        words_out       <= words_out + 32'd1;
      end else if (bus.out_read) begin
        bus.out_empty_n <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_xillybus_ap_fifo_packer.sv
// Directed bench: two packers (pad / discard on close) fed by
// identical source FIFO models.
module tb_xillybus_ap_fifo_packer;
  localparam int IN_W  = 32;
  localparam int RATIO = 4;
  localparam int W     = IN_W * RATIO;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [31:0] words0, words1;
  logic        pad0, pad1;

  int checks = 0;
  int errors = 0;

  xillybus_ap_fifo_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus0 ();
  xillybus_ap_fifo_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus1 ();

  xillybus_ap_fifo_packer #(
    .IN_W(IN_W), .RATIO(RATIO), .PAD_ON_CLOSE(1)
  ) dut0 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus0),
    .words_out(words0), .pad_evt(pad0)
  );

  xillybus_ap_fifo_packer #(
    .IN_W(IN_W), .RATIO(RATIO), .PAD_ON_CLOSE(0)
  ) dut1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus1),
    .words_out(words1), .pad_evt(pad1)
  );

  always #5 ap_clk = ~ap_clk;

  logic [IN_W-1:0] q0[$];
  logic [IN_W-1:0] q1[$];
  logic [W-1:0]    cap0[$];
  logic [W-1:0]    cap1[$];
  int vcnt0, padcnt0, padcnt1, run, maxrun;

  // Standard FIFO models: data appears the cycle after rd_en.
  always @(posedge ap_clk) begin
    if (bus0.src_rd_en && q0.size() > 0) bus0.src_dout <= q0.pop_front();
    if (bus1.src_rd_en && q1.size() > 0) bus1.src_dout <= q1.pop_front();
  end

  always @(negedge ap_clk) begin
    bus0.src_empty = (q0.size() == 0);
    bus1.src_empty = (q1.size() == 0);
  end

  always @(posedge ap_clk) begin
    if (bus0.out_empty_n && bus0.out_read) cap0.push_back(bus0.out_dout);
    if (bus1.out_empty_n && bus1.out_read) cap1.push_back(bus1.out_dout);
    if (bus0.out_empty_n) vcnt0++;
    if (pad0) padcnt0++;
    if (pad1) padcnt1++;
    if (bus0.src_rd_en) run++;
    else run = 0;
    if (run > maxrun) maxrun = run;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input logic [IN_W-1:0] v);
    q0.push_back(v);
    q1.push_back(v);
  endtask

  task automatic set_read(input logic v);
    bus0.out_read = v;
    bus1.out_read = v;
  endtask

  task automatic set_open(input logic v);
    bus0.src_open = v;
    bus1.src_open = v;
  endtask

  task automatic clear_caps;
    cap0.delete();
    cap1.delete();
    vcnt0   = 0;
    padcnt0 = 0;
    padcnt1 = 0;
  endtask

  task automatic wait_caps(input string nm, input int n, input int budget);
    int t = 0;
    while (cap0.size() < n && t < budget) begin
      tick();
      t++;
    end
    checks++;
    if (cap0.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d words, need %0d", nm, cap0.size(), n);
    end
  endtask

  function automatic logic [W-1:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic test_reset;
    ap_rst = 1'b1;
    set_read(1'b0);
    set_open(1'b1);
    push(32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus0.src_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_rd_en cyc%0d: got %b want 0", i, bus0.src_rd_en);
      end
    end
    checks++;
    if (bus0.out_empty_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_empty_n: got %b want 0", bus0.out_empty_n);
    end
    checks++;
    if (words0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_words: got %0d want 0", words0);
    end
    checks++;
    if (bus0.out_dout !== '0 || pad0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_dout: got %h/%b want 0/0", bus0.out_dout, pad0);
    end
    q0.delete();
    q1.delete();
    tick(2);
    ap_rst = 1'b0;
    tick();
  endtask

  task automatic test_pack;
    logic [31:0] w0;
    clear_caps();
    w0 = words0;
    set_read(1'b1);
    for (int i = 1; i <= 4; i++) push(i);
    wait_caps("pack", 1, 20);
    tick(3);
    checks++;
    if (cap0.size() != 1 || cap0[0] !== pack4(1, 2, 3, 4)) begin
      errors++;
      $display("FAIL pack_data: got %h (n=%0d) want %h",
               cap0.size() ? cap0[0] : '0, cap0.size(), pack4(1, 2, 3, 4));
    end
    checks++;
    if (vcnt0 != 1) begin
      errors++;
      $display("FAIL pack_valid_cycles: got %0d want 1", vcnt0);
    end
    checks++;
    if (words0 - w0 !== 32'd1) begin
      errors++;
      $display("FAIL pack_words: got %0d want 1", words0 - w0);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w0;
    clear_caps();
    w0 = words0;
    set_read(1'b0);
    for (int i = 0; i < 12; i++) push(i);
    tick(40);
    checks++;
    if (q0.size() != 4) begin
      errors++;
      $display("FAIL bp_fifo_left: got %0d want 4", q0.size());
    end
    checks++;
    if (bus0.src_rd_en !== 1'b0 || bus0.out_empty_n !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: got rd_en=%b empty_n=%b want 0/1",
               bus0.src_rd_en, bus0.out_empty_n);
    end
    set_read(1'b1);
    wait_caps("bp", 3, 50);
    tick(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cap0.size() <= k ||
          cap0[k] !== pack4(4*k, 4*k+1, 4*k+2, 4*k+3)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h want %h", k,
                 cap0.size() > k ? cap0[k] : '0,
                 pack4(4*k, 4*k+1, 4*k+2, 4*k+3));
      end
    end
    checks++;
    if (words0 - w0 !== 32'd3 || cap0.size() != 3) begin
      errors++;
      $display("FAIL bp_words: got %0d/%0d want 3", words0 - w0, cap0.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w0;
    clear_caps();
    w0 = words0;
    set_read(1'b1);
    maxrun = 0;
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    wait_caps("b2b", 4, 40);
    tick(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap0.size() <= k || cap0[k] !== pack4(32'h100 + 4*k,
          32'h101 + 4*k, 32'h102 + 4*k, 32'h103 + 4*k)) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h", k,
                 cap0.size() > k ? cap0[k] : '0);
      end
    end
    checks++;
    if (maxrun != 16) begin
      errors++;
      $display("FAIL b2b_rd_run: got %0d want 16", maxrun);
    end
    checks++;
    if (words0 - w0 !== 32'd4) begin
      errors++;
      $display("FAIL b2b_words: got %0d want 4", words0 - w0);
    end
  endtask

  task automatic test_pad;
    logic [31:0] w0, w1;
    clear_caps();
    w0 = words0;
    w1 = words1;
    set_read(1'b1);
    push(32'hA);
    push(32'hB);
    tick(5);
    set_open(1'b0);
    tick(10);
    checks++;
    if (cap0.size() != 1 || cap0[0] !== pack4(32'hA, 32'hB, 0, 0)) begin
      errors++;
      $display("FAIL pad_data: got %h (n=%0d) want %h",
               cap0.size() ? cap0[0] : '0, cap0.size(), pack4(32'hA, 32'hB, 0, 0));
    end
    checks++;
    if (padcnt0 != 1 || words0 - w0 !== 32'd1) begin
      errors++;
      $display("FAIL pad_evt: got pulses=%0d words=%0d want 1/1",
               padcnt0, words0 - w0);
    end
    checks++;
    if (cap1.size() != 0 || padcnt1 != 0 || words1 !== w1) begin
      errors++;
      $display("FAIL nopad_silent: got n=%0d pulses=%0d dw=%0d want 0/0/0",
               cap1.size(), padcnt1, words1 - w1);
    end
    // Reopen: both variants must restart at lane 0.
    set_open(1'b1);
    clear_caps();
    for (int i = 1; i <= 4; i++) push(32'h20 + i);
    wait_caps("reopen", 1, 20);
    tick(3);
    checks++;
    if (cap1.size() != 1 || cap1[0] !== pack4(32'h21, 32'h22, 32'h23, 32'h24)) begin
      errors++;
      $display("FAIL nopad_reopen: got %h (n=%0d) want %h",
               cap1.size() ? cap1[0] : '0, cap1.size(),
               pack4(32'h21, 32'h22, 32'h23, 32'h24));
    end
    checks++;
    if (cap0.size() != 1 || cap0[0] !== pack4(32'h21, 32'h22, 32'h23, 32'h24)) begin
      errors++;
      $display("FAIL pad_reopen: got %h (n=%0d)",
               cap0.size() ? cap0[0] : '0, cap0.size());
    end
  endtask

  task automatic test_pad_busy;
    clear_caps();
    set_read(1'b0);
    for (int i = 1; i <= 4; i++) push(32'h30 + i);
    push(32'hC);
    tick(10);
    set_open(1'b0);
    tick(10);
    checks++;
    if (padcnt0 != 0 || bus0.src_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL padbusy_hold: got pulses=%0d rd_en=%b want 0/0",
               padcnt0, bus0.src_rd_en);
    end
    set_read(1'b1);
    wait_caps("padbusy", 2, 20);
    tick(3);
    checks++;
    if (cap0.size() != 2 || cap0[1] !== pack4(32'hC, 0, 0, 0) || padcnt0 != 1) begin
      errors++;
      $display("FAIL padbusy_data: got %h n=%0d pulses=%0d want %h/2/1",
               cap0.size() > 1 ? cap0[1] : '0, cap0.size(), padcnt0,
               pack4(32'hC, 0, 0, 0));
    end
    set_open(1'b1);
    tick();
  endtask

  task automatic test_mid_reset;
    clear_caps();
    set_read(1'b1);
    push(32'h11);
    push(32'h22);
    push(32'h33);
    tick(6);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    for (int i = 5; i <= 8; i++) push(i);
    wait_caps("midrst", 1, 20);
    tick(3);
    checks++;
    if (cap0.size() != 1 || cap0[0] !== pack4(5, 6, 7, 8)) begin
      errors++;
      $display("FAIL midrst_data: got %h (n=%0d) want %h",
               cap0.size() ? cap0[0] : '0, cap0.size(), pack4(5, 6, 7, 8));
    end
    checks++;
    if (words0 !== 32'd1) begin
      errors++;
      $display("FAIL midrst_words: got %0d want 1", words0);
    end
  endtask

  initial begin
    bus0.src_dout = '0;
    bus1.src_dout = '0;
    bus0.src_empty = 1'b1;
    bus1.src_empty = 1'b1;
    run = 0;
    maxrun = 0;
    test_reset();
    test_pack();
    test_backpressure();
    test_back_to_back();
    test_pad();
    test_pad_busy();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
